// File: rtl/kovacs_sequencer_if.sv
// Host-side bundle for the Kovacs switching sequencer.
// Timing controls and samples flow in, the DAC sample and run status flow out.
interface kovacs_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int CYC_W = 16
);
    logic             start_i;
    logic             stop_i;
    logic             update_i;
    logic [CNT_W-1:0] t_high_i;
    logic [CNT_W-1:0] t_low_i;
    logic [CYC_W-1:0] n_cycles_i;
    logic [15:0]      data_i;
    logic [15:0]      data_low_i;
    logic [13:0]      data_o;
    logic [13:0]      indicator_o;
    logic [1:0]       phase_o;
    logic             busy_o;
    logic             done_o;
    logic [CYC_W-1:0] cycle_cnt_o;

    modport master (
        output start_i, stop_i, update_i,
        output t_high_i, t_low_i, n_cycles_i,
        output data_i, data_low_i,
        input  data_o, indicator_o, phase_o,
        input  busy_o, done_o, cycle_cnt_o
    );

    modport slave (
        input  start_i, stop_i, update_i,
        input  t_high_i, t_low_i, n_cycles_i,
        input  data_i, data_low_i,
        output data_o, indicator_o, phase_o,
        output busy_o, done_o, cycle_cnt_o
    );
endinterface

// File: rtl/kovacs_sequencer.sv
// Kovacs HIGH/LOW dwell scheduler driving the DAC mux.
// Timing retunes are shadowed and only take effect at a LOW->HIGH boundary.
module kovacs_sequencer #(
    parameter int          CNT_W    = 32,
    parameter int          CYC_W    = 16,
    parameter logic [13:0] IND_HIGH = 14'd8191
) (
    input logic               clk_i,
    input logic               rst_i,
    kovacs_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] th_q, th_d;
    logic [CNT_W-1:0] tl_q, tl_d;
    logic [CYC_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] sh_th_q, sh_th_d;
    logic [CNT_W-1:0] sh_tl_q, sh_tl_d;
    logic [CYC_W-1:0] sh_n_q, sh_n_d;
    logic             pend_q, pend_d;
    logic [13:0]      data_q, data_d;
    logic [13:0]      ind_q, ind_d;

    logic             start_go;
    logic             high_exp;
    logic             low_exp;
    logic             run_end;
    logic             boundary;
    logic [CYC_W-1:0] cyc_next;
    logic             unused_lsb;

    // Sample LSBs are dropped when narrowing to the 14-bit DAC
    assign unused_lsb = ^{bus.data_i[1:0], bus.data_low_i[1:0]};

    // Phase expiry compares before incrementing, so an all-ones dwell never wraps
    assign start_go = (state_q == S_IDLE) && bus.start_i && !bus.stop_i;
    assign high_exp = (cnt_q == th_q);
    assign low_exp  = (cnt_q == tl_q);
    assign cyc_next = cyc_q + CYC_W'(1);
    assign run_end  = (n_q != '0) && (cyc_next >= n_q);
    assign boundary = (state_q == S_LOW) && !bus.stop_i
                      && low_exp && !run_end;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; stop wins over start and over expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (bus.stop_i) begin
                    state_d = S_IDLE;
                end else if (high_exp) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (bus.stop_i) begin
                    state_d = S_IDLE;
                end else if (low_exp) begin
                    state_d = run_end ? S_DONE : S_HIGH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        bus.phase_o     = state_q;
        bus.busy_o      = (state_q == S_HIGH) || (state_q == S_LOW);
        bus.done_o      = (state_q == S_DONE);
        bus.cycle_cnt_o = cyc_q;
        bus.data_o      = data_q;
        bus.indicator_o = ind_q;
    end

    // Dwell/cycle counters, active timing and shadow bookkeeping
    always_comb begin
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        th_d    = th_q;
        tl_d    = tl_q;
        n_d     = n_q;
        sh_th_d = sh_th_q;
        sh_tl_d = sh_tl_q;
        sh_n_d  = sh_n_q;
        pend_d  = pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    th_d   = bus.t_high_i;
                    tl_d   = bus.t_low_i;
                    n_d    = bus.n_cycles_i;
                    cnt_d  = '0;
                    cyc_d  = '0;
                    pend_d = 1'b0;
                end
            end
            S_HIGH: begin
                if (bus.stop_i) begin
                    pend_d = 1'b0;
                end else if (high_exp) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (bus.stop_i) begin
                    pend_d = 1'b0;
                end else if (low_exp) begin
                    cnt_d = '0;
                    cyc_d = cyc_next;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase

        // A retune coinciding with the boundary bypasses the shadow
        if (boundary) begin
            if (bus.update_i) begin
                th_d = bus.t_high_i;
                tl_d = bus.t_low_i;
                n_d  = bus.n_cycles_i;
            end else if (pend_q) begin
                th_d = sh_th_q;
                tl_d = sh_tl_q;
                n_d  = sh_n_q;
            end
            pend_d = 1'b0;
        end

        if (bus.update_i) begin
            sh_th_d = bus.t_high_i;
            sh_tl_d = bus.t_low_i;
            sh_n_d  = bus.n_cycles_i;
            if (!boundary && !start_go) begin
                pend_d = 1'b1;
            end
        end
    end

    // DAC sample and indicator follow the current phase one clock later
    always_comb begin
        if (state_q == S_HIGH) begin
            data_d = bus.data_i[15:2];
            ind_d  = IND_HIGH;
        end else begin
            data_d = bus.data_low_i[15:2];
            ind_d  = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            cyc_q   <= '0;
            th_q    <= '0;
            tl_q    <= '0;
            n_q     <= '0;
            sh_th_q <= '0;
            sh_tl_q <= '0;
            sh_n_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            ind_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            th_q    <= th_d;
            tl_q    <= tl_d;
            n_q     <= n_d;
            sh_th_q <= sh_th_d;
            sh_tl_q <= sh_tl_d;
            sh_n_q  <= sh_n_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            ind_q   <= ind_d;
        end
    end

endmodule

// File: tb/tb_kovacs_sequencer.sv
// Bench for kovacs_sequencer: directed scenarios plus random pulses,
// compared against a countdown-based behavioural model.
module tb_kovacs_sequencer;

    localparam int CNT_W = 32;
    localparam int CYC_W = 8;
    localparam int VW    = 32 + CYC_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    kovacs_sequencer_if #(.CNT_W(CNT_W), .CYC_W(CYC_W)) bus ();

    kovacs_sequencer #(
        .CNT_W   (CNT_W),
        .CYC_W   (CYC_W),
        .IND_HIGH(14'd8191)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase + clocks remaining in it
    int     m_ph;
    longint m_left;
    longint m_th, m_tl;
    int     m_n, m_cyc;
    longint s_th, s_tl;
    int     s_n;
    bit     m_pend;
    int     m_data, m_ind;

    function automatic void model_reset();
        m_ph = 0; m_left = 0; m_th = 0; m_tl = 0;
        m_n = 0; m_cyc = 0; s_th = 0; s_tl = 0;
        s_n = 0; m_pend = 0; m_data = 0; m_ind = 0;
    endfunction

    function automatic void model_step();
        bit st, sp, up, bnd, took;
        st = bus.start_i; sp = bus.stop_i; up = bus.update_i;
        bnd = 0; took = 0;
        m_data = (m_ph == 1) ? int'(bus.data_i[15:2]) : int'(bus.data_low_i[15:2]);
        m_ind  = (m_ph == 1) ? 8191 : 0;
        case (m_ph)
            0: if (st && !sp) begin
                m_th = longint'(bus.t_high_i);
                m_tl = longint'(bus.t_low_i);
                m_n  = int'(bus.n_cycles_i);
                m_cyc = 0; m_pend = 0; took = 1;
                m_left = m_th; m_ph = 1;
            end
            1: if (sp) begin
                m_ph = 0; m_pend = 0;
            end else if (m_left == 0) begin
                m_ph = 2; m_left = m_tl;
            end else m_left--;
            2: if (sp) begin
                m_ph = 0; m_pend = 0;
            end else if (m_left == 0) begin
                m_cyc = (m_cyc + 1) % (1 << CYC_W);
                if (m_n != 0 && m_cyc >= m_n) m_ph = 3;
                else begin
                    bnd = 1; m_ph = 1;
                    if (up) begin
                        m_th = longint'(bus.t_high_i);
                        m_tl = longint'(bus.t_low_i);
                        m_n  = int'(bus.n_cycles_i);
                    end else if (m_pend) begin
                        m_th = s_th; m_tl = s_tl; m_n = s_n;
                    end
                    m_pend = 0;
                    m_left = m_th;
                end
            end else m_left--;
            default: m_ph = 0;
        endcase
        if (up) begin
            s_th = longint'(bus.t_high_i);
            s_tl = longint'(bus.t_low_i);
            s_n  = int'(bus.n_cycles_i);
            if (!bnd && !took) m_pend = 1;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0]       p;
        logic             b, d;
        logic [CYC_W-1:0] c;
        logic [13:0]      dt, id;
        p  = 2'(m_ph);
        b  = (m_ph == 1) || (m_ph == 2);
        d  = (m_ph == 3);
        c  = CYC_W'(m_cyc);
        dt = 14'(m_data);
        id = 14'(m_ind);
        return {p, b, d, c, dt, id};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.phase_o, bus.busy_o, bus.done_o,
                bus.cycle_cnt_o, bus.data_o, bus.indicator_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        bus.data_i     = 16'($urandom);
        bus.data_low_i = 16'($urandom);
    endtask

    task automatic test_reset();
        bus.start_i = 0; bus.stop_i = 0; bus.update_i = 0;
        bus.t_high_i = 0; bus.t_low_i = 0; bus.n_cycles_i = 0;
        bus.data_i = 16'hFFFF; bus.data_low_i = 16'hFFFF;
        model_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_async got %h exp 0", dut_vec());
        end
        tick();
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_clocked got %h exp 0", dut_vec());
        end
        #2 rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle got %h exp %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int ph_tab[15] = '{0, 1, 1, 1, 1, 2, 2, 1, 1, 1, 1, 2, 2, 3, 0};
        logic [13:0] ind_e;
        bus.t_high_i = 3; bus.t_low_i = 1; bus.n_cycles_i = 2;
        bus.start_i = 1;
        for (int j = 1; j <= 14; j++) begin
            tick();
            bus.start_i = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_model clk%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
            checks++;
            if (bus.phase_o !== 2'(ph_tab[j])) begin
                errors++;
                $display("FAIL basic_phase clk%0d got %0d exp %0d", j, bus.phase_o, ph_tab[j]);
            end
            ind_e = ((j >= 2 && j <= 5) || (j >= 8 && j <= 11)) ? 14'd8191 : 14'd0;
            checks++;
            if (bus.indicator_o !== ind_e) begin
                errors++;
                $display("FAIL basic_ind clk%0d got %0d exp %0d", j, bus.indicator_o, ind_e);
            end
        end
        checks++;
        if (bus.cycle_cnt_o !== CYC_W'(2)) begin
            errors++;
            $display("FAIL basic_cyc got %0d exp 2", bus.cycle_cnt_o);
        end
    endtask

    task automatic test_fast_toggle();
        logic [CYC_W-1:0] prev_cc;
        logic [15:0]      dl;
        bit               wrapped, done_seen;
        logic [1:0]       pe;
        prev_cc = 0; wrapped = 0; done_seen = 0;
        bus.t_high_i = 0; bus.t_low_i = 0; bus.n_cycles_i = 0;
        bus.start_i = 1;
        for (int j = 1; j <= 540; j++) begin
            tick();
            bus.start_i = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL toggle_model clk%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
            pe = (j % 2 == 1) ? 2'd1 : 2'd2;
            checks++;
            if (bus.phase_o !== pe) begin
                errors++;
                $display("FAIL toggle_phase clk%0d got %0d exp %0d", j, bus.phase_o, pe);
            end
            if (prev_cc == '1 && bus.cycle_cnt_o == '0) wrapped = 1;
            if (bus.done_o) done_seen = 1;
            prev_cc = bus.cycle_cnt_o;
        end
        checks++;
        if (wrapped !== 1'b1) begin
            errors++;
            $display("FAIL toggle_wrap got %0d exp 1", wrapped);
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL toggle_nodone got %0d exp 0", done_seen);
        end
        bus.stop_i = 1;
        tick();
        bus.stop_i = 0;
        checks++;
        if (bus.phase_o !== 2'd0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL toggle_stop got %h exp %h", dut_vec(), exp_vec());
        end
        dl = bus.data_low_i;
        tick();
        checks++;
        if (bus.data_o !== dl[15:2]) begin
            errors++;
            $display("FAIL toggle_idle_data got %h exp %h", bus.data_o, dl[15:2]);
        end
    endtask

    task automatic test_abort();
        bit done_seen;
        done_seen = 0;
        bus.t_high_i = 10; bus.t_low_i = 3; bus.n_cycles_i = 1;
        bus.start_i = 1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            bus.start_i = 0;
            bus.stop_i  = (j == 3);
            if (bus.done_o) done_seen = 1;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abort_model clk%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
        end
        bus.stop_i = 0;
        checks++;
        if (bus.phase_o !== 2'd0 || done_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got ph=%0d done=%0d exp ph=0 done=0", bus.phase_o, done_seen);
        end
        bus.start_i = 1; bus.stop_i = 1;
        for (int j = 0; j < 3; j++) begin
            tick();
            bus.start_i = 0; bus.stop_i = 0;
            checks++;
            if (bus.phase_o !== 2'd0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start_stop_idle got %h exp %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_shadow();
        int ph_tab[26] = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 1, 1,
                           2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 2};
        bus.t_high_i = 5; bus.t_low_i = 5; bus.n_cycles_i = 0;
        bus.start_i = 1;
        for (int j = 1; j <= 25; j++) begin
            tick();
            bus.start_i = 0;
            bus.update_i = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL shadow_model clk%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
            checks++;
            if (bus.phase_o !== 2'(ph_tab[j])) begin
                errors++;
                $display("FAIL shadow_phase clk%0d got %0d exp %0d", j, bus.phase_o, ph_tab[j]);
            end
            if (j == 2) begin
                bus.update_i = 1; bus.t_high_i = 1;
            end else if (j == 20) begin
                bus.update_i = 1; bus.t_high_i = 3;
            end else begin
                bus.t_high_i = 9;
            end
        end
        bus.stop_i = 1;
        tick();
        bus.stop_i = 0;
    endtask

    task automatic test_start_busy();
        int ph_tab[21] = '{0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1,
                           2, 2, 2, 2, 3, 0};
        bus.t_high_i = 4; bus.t_low_i = 3; bus.n_cycles_i = 2;
        bus.start_i = 1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            bus.start_i = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL busy_model clk%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
            checks++;
            if (bus.phase_o !== 2'(ph_tab[j])) begin
                errors++;
                $display("FAIL busy_phase clk%0d got %0d exp %0d", j, bus.phase_o, ph_tab[j]);
            end
            if (j == 2 || j == 7 || j == 12) begin
                bus.start_i = 1; bus.t_high_i = 0;
            end
        end
        checks++;
        if (bus.cycle_cnt_o !== CYC_W'(2)) begin
            errors++;
            $display("FAIL busy_cyc got %0d exp 2", bus.cycle_cnt_o);
        end
    endtask

    task automatic test_max_dwell();
        bus.t_high_i = 32'hFFFF_FFFF; bus.t_low_i = 0; bus.n_cycles_i = 0;
        bus.start_i = 1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            bus.start_i = 0;
            checks++;
            if (bus.phase_o !== 2'd1 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL maxdwell clk%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
        end
        bus.stop_i = 1;
        tick();
        bus.stop_i = 0;
    endtask

    task automatic test_reset_midrun();
        bus.t_high_i = 2; bus.t_low_i = 6; bus.n_cycles_i = 0;
        bus.start_i = 1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            bus.start_i = 0;
        end
        checks++;
        if (bus.phase_o !== 2'd2 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midrun_low got %h exp %h", dut_vec(), exp_vec());
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL midrun_async got %h exp 0", dut_vec());
        end
        tick();
        #2 rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (bus.phase_o !== 2'd0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midrun_idle got %h exp %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            bus.start_i    = ($urandom_range(9) == 0);
            bus.stop_i     = ($urandom_range(39) == 0);
            bus.update_i   = ($urandom_range(14) == 0);
            bus.t_high_i   = $urandom_range(5);
            bus.t_low_i    = $urandom_range(5);
            bus.n_cycles_i = CYC_W'($urandom_range(3));
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model it%0d got %h exp %h", j, dut_vec(), exp_vec());
            end
        end
        bus.start_i = 0; bus.stop_i = 0; bus.update_i = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fast_toggle();
        test_abort();
        test_shadow();
        test_start_busy();
        test_max_dwell();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
